store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, store data width.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL provide parameter DEPTH, default 4, entry count; a power of 2, at least 2.
REQ-004 SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL provide port st_valid  input  1  store request from the MEM stage.
REQ-007 SHALL provide port st_funct3  input  3  store type: 000 sb, 001 sh, 010 sw.
REQ-008 SHALL provide port st_addr  input  ADDR_WIDTH  store byte address.
REQ-009 SHALL provide port st_data  input  DATA_WIDTH  store data, low bytes significant for sb/sh.
REQ-010 SHALL provide port st_ready  output  1  buffer can accept a store this cycle.
REQ-011 SHALL provide port ld_valid  input  1  load request from the MEM stage.
REQ-012 SHALL provide port ld_funct3  input  3  load type, passed through to memory.
REQ-013 SHALL provide port ld_addr  input  ADDR_WIDTH  load byte address.
REQ-014 SHALL provide port ld_hazard  output  1  load must stall this cycle.
REQ-015 SHALL provide port mem_wr_en  output  1  write enable to data memory.
REQ-016 SHALL provide port mem_funct3  output  3  funct3 to data memory.
REQ-017 SHALL provide port mem_addr  output  ADDR_WIDTH  shared read/write address to data memory.
REQ-018 SHALL provide port mem_wr_data  output  DATA_WIDTH  write data to data memory.
REQ-019 SHALL provide port misalign_err  output  1  one-cycle pulse flagging a rejected store.
REQ-020 SHALL provide port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-021 SHALL hold stores in a FIFO of DEPTH entries, each storing {funct3, addr, data}, drained in order.
REQ-022 SHALL drive st_ready = (count < DEPTH) combinationally, with no look-ahead on a same-cycle drain.
REQ-023 SHALL accept a store when st_valid && st_ready && the store is legal; accepted stores are enqueued at the clock edge.
REQ-024 SHALL treat as illegal: sh with addr[0]=1; sw with addr[1:0]!=00; funct3 not in {000,001,010}.
REQ-025 SHALL not enqueue an illegal store and SHALL assert misalign_err for exactly the following cycle (registered).
REQ-026 SHALL assert ld_hazard combinationally when ld_valid is high and any occupied entry has addr[ADDR_WIDTH-1:2] equal to ld_addr[ADDR_WIDTH-1:2].
REQ-027 SHALL grant the memory port to the load when ld_valid && !ld_hazard: mem_addr=ld_addr, mem_funct3=ld_funct3, mem_wr_en=0.
REQ-028 SHALL otherwise grant the port to the drain when count>0: mem_addr, mem_funct3 and mem_wr_data from the head entry, and mem_wr_en=1; the head is dequeued at that edge.
REQ-029 SHALL drive mem_wr_en=0, mem_addr=0, mem_funct3=0 and mem_wr_data=0 when neither the load nor the drain owns the port.
REQ-030 SHALL keep draining while a hazarded load stalls, so the hazard clears once the matching entries retire, with no deadlock.
REQ-031 SHALL leave count unchanged when an enqueue and a dequeue happen in the same cycle; SHALL increment it on enqueue alone and decrement it on dequeue alone.
REQ-032 SHALL wrap read and write pointers modulo DEPTH.
REQ-033 SHALL give a store accepted in cycle N its earliest drain in cycle N+1, so it never bypasses within a cycle.

Reset
REQ-034 SHALL, while reset is high at a clock edge, clear both pointers, set count=0 and clear misalign_err; buffered stores are discarded.
REQ-035 SHALL force mem_wr_en=0 combinationally while reset is high, even if entries are held.
REQ-036 SHALL give reset priority over a simultaneous enqueue or dequeue; the first enqueue after reset lands in entry 0.

Verification
REQ-037 SHALL verify basic drain: sw 0x10 data 0xDEADBEEF, then idle -> next cycle mem_wr_en=1, mem_addr=0x10, mem_funct3=010, mem_wr_data=0xDEADBEEF; count 1->0.
REQ-038 SHALL verify full: 4 stores while ld_valid is held high to unrelated addr 0x100 -> count=4, st_ready=0, a 5th store is not taken, mem_wr_en=0; dropping ld_valid drains 4 writes in order over 4 cycles.
REQ-039 SHALL verify hazard: buffer sb 0x23 data 0xAB, same cycle as ld_valid lw 0x20 -> ld_hazard=1, write drains (mem_addr=0x23, funct3 000); next cycle ld_hazard=0, mem_addr=0x20, mem_wr_en=0.
REQ-040 SHALL verify misalignment: sh 0x31, then sw 0x42 -> neither enqueued, count stays 0, misalign_err pulses one cycle after each.
REQ-041 SHALL verify simultaneous events: count=2, with enqueue and drain in the same cycle -> count stays 2; pointer wrap after 9 sequential stores keeps FIFO order.
REQ-042 SHALL verify reset mid-operation: count=3, assert reset for one cycle -> mem_wr_en=0 during reset, count=0 afterward, no stale write is ever issued.

Source files
------------

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   In-order store buffer between the MEM stage and a single-ported data memory.
//   Stores are queued in a DEPTH-entry FIFO and drained to memory whenever the
//   port is not needed by a load. A load whose word address matches any queued
//   store is stalled (ld_hazard) until the matching entries have drained.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   st_valid/funct3/addr/data, st_ready   : store request / accept
//   ld_valid/funct3/addr, ld_hazard       : load request / stall
//   mem_wr_en/funct3/addr/wr_data         : shared data-memory port
//   misalign_err          : one-cycle pulse after a rejected (illegal) store
//   count                 : number of occupied entries
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        st_valid,
    input  logic [2:0]                  st_funct3,
    input  logic [ADDR_WIDTH-1:0]       st_addr,
    input  logic [DATA_WIDTH-1:0]       st_data,
    output logic                        st_ready,
    input  logic                        ld_valid,
    input  logic [2:0]                  ld_funct3,
    input  logic [ADDR_WIDTH-1:0]       ld_addr,
    output logic                        ld_hazard,
    output logic                        mem_wr_en,
    output logic [2:0]                  mem_funct3,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0]       mem_wr_data,
    output logic                        misalign_err,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [2:0]            funct3;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t             entries_q [DEPTH];
    entry_t             entries_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               misalign_err_q, misalign_err_d;

    logic               st_legal;
    logic               enq;
    logic               deq;
    logic               load_gnt;
    logic [DEPTH-1:0]   occupied;
    entry_t             head;

    // Alignment / type legality of the incoming store
    always_comb begin
        st_legal = 1'b0;
        case (st_funct3)
            3'b000:  st_legal = 1'b1;
            3'b001:  st_legal = (st_addr[0] == 1'b0);
            3'b010:  st_legal = (st_addr[1:0] == 2'b00);
            default: st_legal = 1'b0;
        endcase
    end

    // No look-ahead on a same-cycle drain: a full buffer refuses even if draining
    assign st_ready = (count_q < CNT_W'(DEPTH));
    assign enq      = st_valid && st_ready && st_legal;

    // Slot i is occupied when its distance from the head is below count
    always_comb begin
        logic [PTR_W-1:0] slot_off;
        occupied = '0;
        slot_off = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_off    = PTR_W'(i) - rd_ptr_q;
            occupied[i] = ({1'b0, slot_off} < count_q);
        end
    end

    // Word-granular address match against every queued store
    always_comb begin
        ld_hazard = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (occupied[i] &&
                entries_q[i].addr[ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2]) begin
                ld_hazard = ld_valid;
            end
        end
    end

    // Port arbitration: unstalled load first, else drain the head
    assign head     = entries_q[rd_ptr_q];
    assign load_gnt = ld_valid && !ld_hazard;
    assign deq      = !load_gnt && (count_q != '0) && !reset;

    always_comb begin
        mem_wr_en   = 1'b0;
        mem_funct3  = 3'b000;
        mem_addr    = '0;
        mem_wr_data = '0;
        if (load_gnt) begin
            mem_funct3 = ld_funct3;
            mem_addr   = ld_addr;
        end else if (deq) begin
            mem_wr_en   = 1'b1;
            mem_funct3  = head.funct3;
            mem_addr    = head.addr;
            mem_wr_data = head.data;
        end
    end

    // Next-state for FIFO pointers, occupancy and error pulse
    always_comb begin
        entries_d      = entries_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        misalign_err_d = st_valid && st_ready && !st_legal;

        if (enq) begin
            entries_d[wr_ptr_q] = '{funct3: st_funct3, addr: st_addr, data: st_data};
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            misalign_err_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    assign misalign_err = misalign_err_q;
    assign count        = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//   Directed bench for store_buffer (DATA_WIDTH=32, ADDR_WIDTH=32, DEPTH=4).
//   Inputs change after the falling edge; combinational outputs are sampled
//   #1 later, registered outputs at the following falling edge.
// -----------------------------------------------------------------------------
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [2:0]  st_funct3;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [2:0]  ld_funct3;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        mem_wr_en;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        misalign_err;
    logic [2:0]  count;

    int passed = 0;
    int total  = 0;

    store_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .st_valid     (st_valid),
        .st_funct3    (st_funct3),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_ready     (st_ready),
        .ld_valid     (ld_valid),
        .ld_funct3    (ld_funct3),
        .ld_addr      (ld_addr),
        .ld_hazard    (ld_hazard),
        .mem_wr_en    (mem_wr_en),
        .mem_funct3   (mem_funct3),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .misalign_err (misalign_err),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        st_valid  = 1'b1;
        st_funct3 = f3;
        st_addr   = a;
        st_data   = d;
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] a);
        ld_valid  = 1'b1;
        ld_funct3 = f3;
        ld_addr   = a;
    endtask

    task automatic chk_write(input string tag, input logic [31:0] a, input logic [2:0] f3,
                             input logic [31:0] d);
        chk({tag, "_wr_en"}, 64'(mem_wr_en), 64'd1);
        chk({tag, "_addr"},  64'(mem_addr),  64'(a));
        chk({tag, "_f3"},    64'(mem_funct3), 64'(f3));
        chk({tag, "_data"},  64'(mem_wr_data), 64'(d));
    endtask

    initial begin
        reset     = 1'b1;
        st_valid  = 1'b0;
        st_funct3 = 3'b000;
        st_addr   = '0;
        st_data   = '0;
        ld_valid  = 1'b0;
        ld_funct3 = 3'b000;
        ld_addr   = '0;

        // ---- reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(st_ready), 64'd1);
        chk("rst_wr_en", 64'(mem_wr_en), 64'd0);
        chk("rst_misalign", 64'(misalign_err), 64'd0);
        reset = 1'b0;

        // ---- basic drain: sw 0x10
        @(negedge clk);
        store(3'b010, 32'h10, 32'hDEADBEEF);
        #1;
        chk("basic_no_bypass", 64'(mem_wr_en), 64'd0);
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        chk("basic_count1", 64'(count), 64'd1);
        chk_write("basic", 32'h10, 3'b010, 32'hDEADBEEF);
        @(negedge clk);
        #1;
        chk("basic_count0", 64'(count), 64'd0);
        chk("basic_idle_wr_en", 64'(mem_wr_en), 64'd0);
        chk("basic_idle_addr", 64'(mem_addr), 64'd0);
        chk("basic_idle_data", 64'(mem_wr_data), 64'd0);

        // ---- full: 4 stores while an unrelated load holds the port
        load(3'b010, 32'h100);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            store(3'b010, 32'h200 + 32'(4 * k), 32'h11 * 32'(k + 1));
            #1;
            chk("full_load_owns_wr_en", 64'(mem_wr_en), 64'd0);
            chk("full_load_addr", 64'(mem_addr), 64'h100);
        end
        @(negedge clk);
        store(3'b010, 32'h210, 32'h55);
        #1;
        chk("full_count4", 64'(count), 64'd4);
        chk("full_ready0", 64'(st_ready), 64'd0);
        chk("full_no_hazard", 64'(ld_hazard), 64'd0);
        @(negedge clk);
        #1;
        chk("full_5th_refused", 64'(count), 64'd4);
        st_valid = 1'b0;
        ld_valid = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk_write("full_drain", 32'h200 + 32'(4 * k), 3'b010, 32'h11 * 32'(k + 1));
            @(negedge clk);
            #1;
        end
        chk("full_empty", 64'(count), 64'd0);

        // ---- hazard: buffered sb 0x23 blocks lw 0x20
        store(3'b000, 32'h23, 32'hAB);
        @(negedge clk);
        st_valid = 1'b0;
        load(3'b010, 32'h20);
        #1;
        chk("haz_hazard1", 64'(ld_hazard), 64'd1);
        chk_write("haz_drain", 32'h23, 3'b000, 32'hAB);
        @(negedge clk);
        #1;
        chk("haz_hazard0", 64'(ld_hazard), 64'd0);
        chk("haz_load_addr", 64'(mem_addr), 64'h20);
        chk("haz_load_f3", 64'(mem_funct3), 64'd2);
        chk("haz_load_wr_en", 64'(mem_wr_en), 64'd0);
        ld_valid = 1'b0;

        // ---- misalignment: sh 0x31, sw 0x42, funct3 011 rejected; sh 0x32 legal
        @(negedge clk);
        store(3'b001, 32'h31, 32'h1234);
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        chk("mis_sh_pulse", 64'(misalign_err), 64'd1);
        chk("mis_sh_count", 64'(count), 64'd0);
        @(negedge clk);
        #1;
        chk("mis_sh_clear", 64'(misalign_err), 64'd0);
        store(3'b010, 32'h42, 32'h5678);
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        chk("mis_sw_pulse", 64'(misalign_err), 64'd1);
        chk("mis_sw_count", 64'(count), 64'd0);
        @(negedge clk);
        #1;
        chk("mis_sw_clear", 64'(misalign_err), 64'd0);
        store(3'b011, 32'h40, 32'h9);
        @(negedge clk);
        store(3'b001, 32'h32, 32'hBEEF);
        #1;
        chk("mis_f3_pulse", 64'(misalign_err), 64'd1);
        chk("mis_f3_count", 64'(count), 64'd0);
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        chk("mis_sh_ok_no_err", 64'(misalign_err), 64'd0);
        chk("mis_sh_ok_count", 64'(count), 64'd1);
        chk_write("mis_sh_ok", 32'h32, 3'b001, 32'hBEEF);
        @(negedge clk);

        // ---- simultaneous enqueue + drain at count=2
        load(3'b010, 32'h100);
        store(3'b010, 32'h300, 32'hA0);
        @(negedge clk);
        store(3'b010, 32'h304, 32'hA1);
        @(negedge clk);
        ld_valid = 1'b0;
        store(3'b010, 32'h308, 32'hA2);
        #1;
        chk("sim_count2_before", 64'(count), 64'd2);
        chk_write("sim_drain0", 32'h300, 3'b010, 32'hA0);
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        chk("sim_count2_after", 64'(count), 64'd2);
        chk_write("sim_drain1", 32'h304, 3'b010, 32'hA1);
        @(negedge clk);
        #1;
        chk_write("sim_drain2", 32'h308, 3'b010, 32'hA2);
        @(negedge clk);
        #1;
        chk("sim_empty", 64'(count), 64'd0);

        // ---- pointer wrap: 9 back-to-back stores drain in order
        for (int k = 0; k < 9; k++) begin
            store(3'b010, 32'h400 + 32'(4 * k), 32'h1000 + 32'(k));
            #1;
            if (k > 0) begin
                chk_write("wrap", 32'h400 + 32'(4 * (k - 1)), 3'b010, 32'h1000 + 32'(k - 1));
            end
            @(negedge clk);
        end
        st_valid = 1'b0;
        #1;
        chk_write("wrap_last", 32'h420, 3'b010, 32'h1008);
        @(negedge clk);
        #1;
        chk("wrap_empty", 64'(count), 64'd0);

        // ---- reset mid-operation with 3 entries held
        load(3'b010, 32'h100);
        for (int k = 0; k < 3; k++) begin
            store(3'b010, 32'h500 + 32'(4 * k), 32'hC0 + 32'(k));
            @(negedge clk);
        end
        st_valid = 1'b0;
        #1;
        chk("rstmid_count3", 64'(count), 64'd3);
        ld_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("rstmid_wr_en_forced0", 64'(mem_wr_en), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstmid_count0", 64'(count), 64'd0);
        chk("rstmid_no_stale", 64'(mem_wr_en), 64'd0);
        store(3'b010, 32'h600, 32'hF00D);
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        chk_write("rstmid_first", 32'h600, 3'b010, 32'hF00D);
        @(negedge clk);
        #1;
        chk("rstmid_final_empty", 64'(count), 64'd0);
        chk("rstmid_final_idle", 64'(mem_wr_en), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
